wb_spi_slave: RTL and testbench
===============================

# wb_spi_slave

SPI target (slave) with a Wishbone register interface; the receiving end of the SPI links driven by our SPI master peripherals. It lets the SoC act as an SPI device toward an external controller. A byte shifted in on mosi becomes readable over Wishbone. A byte written over Wishbone is shifted out on miso during the next transfer. All SPI pins are oversampled in the system clock domain (mode 0, MSB first, 8-bit frames).

## Interface
- SPI_SLV_SYNC, default 2: synchronizer depth on sclk/mosi/cs_n. Legal values are 2 or 3.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- wb_adr_i  in  32  byte address; only [3:2] decoded.
- wb_dat_i  in  32  write data; [7:0] used.
- wb_dat_o  out  32  read data, registered.
- wb_we_i, wb_stb_i, wb_cyc_i  in  1 each  Wishbone classic controls.
- wb_ack_o  out  1  single-cycle acknowledge.
- sclk, mosi, cs_n  in  1 each  asynchronous SPI inputs from the external master; cs_n is active-low.
- miso  out  1  serial data to the master; 0 while cs_n is high.
- irq  out  1  only when SPI_SLV_IRQ_EN is defined.

## Operation
- Registers, selected by adr[3:2]:
  - 0 DATA: a read returns {24'b0, rx_data} and clears rx_full. A write loads tx_data and sets tx_full.
  - 1 STATUS: read-only bits are [0] rx_full, [1] tx_full, [4] busy (synchronized cs_n low). Write-1-to-clear bits are [2] overrun, [3] underrun.
  - 2, 3: reads return 0; writes are ignored.
- Frame start (synchronized cs_n falling): bit_cnt=0, then load shift_tx.
  - If tx_full: shift_tx=tx_data, clear tx_full.
  - Otherwise: shift_tx=8'h00, set underrun.
- miso = shift_tx[7] while cs_n is low.
- sclk rising (synchronized): shift_rx={shift_rx[6:0],mosi}, bit_cnt++.
- On the 8th rising edge:
  - If rx_full=0: rx_data is updated and rx_full is set.
  - If rx_full=1 and a DATA read is not completing this cycle: the byte is discarded, rx_data is kept, and overrun is set.
- sclk falling: after bit 8, wrap bit_cnt to 0 and reload shift_tx per the frame-start rule (back-to-back bytes). Otherwise shift_tx<<=1.
- cs_n rising mid-byte: the partial byte is discarded, bit_cnt=0, and no flag changes.
- Simultaneous events:
  - DATA read in the same cycle as byte completion: the read returns the old byte, the new byte is stored, rx_full stays 1, and no overrun is raised.
  - TX write in the same cycle as a shift_tx load: the load uses the pre-write state. If that load underruns, the write still sets tx_full for the next byte.
- Reset: all flags 0, rx_data=0, tx_data=0, shift registers 0, bit_cnt=0, synchronizers at idle (sclk=0, cs_n=1).

## Timing
- Input path is a SPI_SLV_SYNC-stage synchronizer plus one edge-detect register.
  - A pin edge takes effect SPI_SLV_SYNC+1 clk edges later (3 at default).
- rx_full rises 3 clk after the 8th sclk rising edge at the pin.
- miso updates 3 clk after a sclk falling edge (or cs_n falling edge) at the pin.
- Requirement: sclk high and low phases must each last ≥4 clk, i.e. f_sclk ≤ f_clk/8.
- cs_n falling to the first sclk rising edge must be ≥4 clk.
- Wishbone:
  - wb_ack_o <= valid & ~wb_ack_o, where valid = stb & cyc. The ack is 1 cycle after valid, never two consecutive cycles.
  - The register side effect (flag clear/set, tx_data load) occurs on the cycle ack is asserted.
  - wb_dat_o is valid with ack.
- Reset values: wb_ack_o=0, wb_dat_o=0, miso=0, irq=0.
- Asserting rst_n low mid-frame aborts immediately. After release the block waits for the next cs_n falling edge.

## Configuration
- SPI_SLV_IRQ_EN defined:
  - Adds a CTRL register at adr index 2: [0] rx_ie, [1] err_ie, reset value 0.
  - Adds the irq output: irq = (rx_full & rx_ie) | ((overrun|underrun) & err_ie), registered, 1 clk after the flag changes.
- Not defined: no irq port; index 2 reads 0 and ignores writes.

## Test plan
- Reset mid-frame: drive cs_n low and 4 sclk, pulse rst_n low → all flags 0, miso=0. Then a full frame of 0x3C → rx_data=0x3C with no overrun.
- Write DATA=0xA5, master sends 0x5A at clk/8 → master receives 0xA5. STATUS reads 0x01 (rx_full) and DATA reads 0x5A. A second STATUS read gives 0x00.
- Two back-to-back bytes 0x11, 0x22 with no DATA read → rx_data=0x11 and overrun=1. Writing STATUS=0x04 clears the bit.
- No TX write, master sends 0xFF → miso shifts 0x00 and underrun=1. With SPI_SLV_IRQ_EN defined and CTRL=0x2, irq=1 until STATUS=0x08 is written.
- cs_n rises after 5 bits → rx_full stays 0. A following full frame 0x81 is received correctly.
- DATA read coincident with completion of byte 0x77 (old byte 0x66) → read returns 0x66, rx_full=1, overrun=0, and the next read returns 0x77.

Source files
------------

// File: rtl/wb_spi_slave.sv
// wb_spi_slave: SPI mode-0 target (MSB first, 8-bit frames) behind a Wishbone register file.
// Define SPI_SLV_IRQ_EN to add the CTRL register (index 2) and the irq output.
module wb_spi_slave #(
    parameter int unsigned SPI_SLV_SYNC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        cs_n,
    output logic        miso
`ifdef SPI_SLV_IRQ_EN
    ,
    output logic        irq
`endif
);

    logic [SPI_SLV_SYNC-1:0] sclk_sync, mosi_sync, cs_sync;
    logic sclk_s, mosi_s, cs_s;
    logic sclk_q, cs_q;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_rx_q, shift_rx_d;
    logic [7:0] shift_tx_q, shift_tx_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       rx_full_q, rx_full_d;
    logic       tx_full_q, tx_full_d;
    logic       overrun_q, overrun_d;
    logic       underrun_q, underrun_d;
    logic       load, byte_done;

    logic        valid, acc, rd, wr;
    logic [1:0]  sel;
    logic        data_rd, data_wr, stat_wr;
    logic [31:0] rd_data;
    logic        unused;

    assign sclk_s = sclk_sync[SPI_SLV_SYNC-1];
    assign mosi_s = mosi_sync[SPI_SLV_SYNC-1];
    assign cs_s   = cs_sync[SPI_SLV_SYNC-1];

    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign cs_fall   = ~cs_s & cs_q;
    assign cs_rise   = cs_s & ~cs_q;

    // cs_q drops on the same edge that loads shift_tx, so miso never shows a stale bit
    assign miso = ~cs_q & shift_tx_q[7];

    assign valid   = wb_stb_i & wb_cyc_i;
    assign acc     = valid & ~wb_ack_o;
    assign rd      = acc & ~wb_we_i;
    assign wr      = acc & wb_we_i;
    assign sel     = wb_adr_i[3:2];
    assign data_rd = rd & (sel == 2'd0);
    assign data_wr = wr & (sel == 2'd0);
    assign stat_wr = wr & (sel == 2'd1);

    assign unused = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8]};

`ifdef SPI_SLV_IRQ_EN
    logic [1:0] ctrl_q, ctrl_d;
    logic       ctrl_wr;
    assign ctrl_wr = wr & (sel == 2'd2);
`endif

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_rx_d = shift_rx_q;
        shift_tx_d = shift_tx_q;
        rx_data_d  = rx_data_q;
        tx_data_d  = tx_data_q;
        rx_full_d  = rx_full_q;
        tx_full_d  = tx_full_q;
        overrun_d  = overrun_q;
        underrun_d = underrun_q;
        load       = 1'b0;
        byte_done  = 1'b0;
`ifdef SPI_SLV_IRQ_EN
        ctrl_d = ctrl_q;
        if (ctrl_wr) ctrl_d = wb_dat_i[1:0];
`endif

        if (cs_fall) begin
            bit_cnt_d = 4'd0;
            load      = 1'b1;
        end else if (cs_rise) begin
            bit_cnt_d = 4'd0;
        end else if (!cs_s) begin
            if (sclk_rise) begin
                shift_rx_d = {shift_rx_q[6:0], mosi_s};
                bit_cnt_d  = bit_cnt_q + 4'd1;
                byte_done  = (bit_cnt_q == 4'd7);
            end else if (sclk_fall) begin
                if (bit_cnt_q == 4'd8) begin
                    bit_cnt_d = 4'd0;
                    load      = 1'b1;
                end else begin
                    shift_tx_d = {shift_tx_q[6:0], 1'b0};
                end
            end
        end

        if (data_rd) rx_full_d = 1'b0;
        if (data_wr) tx_data_d = wb_dat_i[7:0];
        if (stat_wr) begin
            if (wb_dat_i[2]) overrun_d  = 1'b0;
            if (wb_dat_i[3]) underrun_d = 1'b0;
        end

        // Loads see pre-write tx state; a coincident write still arms the next byte
        if (load) begin
            if (tx_full_q) begin
                shift_tx_d = tx_data_q;
                tx_full_d  = 1'b0;
            end else begin
                shift_tx_d = 8'h00;
                underrun_d = 1'b1;
            end
        end
        if (data_wr) tx_full_d = 1'b1;

        if (byte_done) begin
            if (!rx_full_q || data_rd) begin
                rx_data_d = {shift_rx_q[6:0], mosi_s};
                rx_full_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (sel)
            2'd0: rd_data = {24'b0, rx_data_q};
            2'd1: rd_data = {27'b0, ~cs_s, underrun_q, overrun_q, tx_full_q, rx_full_q};
`ifdef SPI_SLV_IRQ_EN
            2'd2: rd_data = {30'b0, ctrl_q};
`endif
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync  <= '0;
            mosi_sync  <= '0;
            cs_sync    <= '1;
            sclk_q     <= 1'b0;
            cs_q       <= 1'b1;
            bit_cnt_q  <= 4'd0;
            shift_rx_q <= 8'h00;
            shift_tx_q <= 8'h00;
            rx_data_q  <= 8'h00;
            tx_data_q  <= 8'h00;
            rx_full_q  <= 1'b0;
            tx_full_q  <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
            wb_ack_o   <= 1'b0;
            wb_dat_o   <= 32'h0;
        end else begin
            sclk_sync  <= {sclk_sync[SPI_SLV_SYNC-2:0], sclk};
            mosi_sync  <= {mosi_sync[SPI_SLV_SYNC-2:0], mosi};
            cs_sync    <= {cs_sync[SPI_SLV_SYNC-2:0], cs_n};
            sclk_q     <= sclk_s;
            cs_q       <= cs_s;
            bit_cnt_q  <= bit_cnt_d;
            shift_rx_q <= shift_rx_d;
            shift_tx_q <= shift_tx_d;
            rx_data_q  <= rx_data_d;
            tx_data_q  <= tx_data_d;
            rx_full_q  <= rx_full_d;
            tx_full_q  <= tx_full_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
            wb_ack_o   <= valid & ~wb_ack_o;
            if (rd) wb_dat_o <= rd_data;
        end
    end

`ifdef SPI_SLV_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= 2'b00;
            irq    <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            irq    <= (rx_full_q & ctrl_q[0]) | ((overrun_q | underrun_q) & ctrl_q[1]);
        end
    end
`endif

endmodule

// File: tb/tb_wb_spi_slave.sv
// Self-checking bench for wb_spi_slave: directed scenarios plus randomized frames,
// checked against a transaction-level model of the register/flag behaviour.
module tb_wb_spi_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wb_adr = '0, wb_dat = '0;
    logic [31:0] wb_dat_o;
    logic        wb_we = 1'b0, wb_stb = 1'b0, wb_cyc = 1'b0;
    logic        wb_ack_o;
    logic        sclk = 1'b0, mosi = 1'b0, cs_n = 1'b1;
    logic        miso;
`ifdef SPI_SLV_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int failures = 0;

    // Transaction-level model state
    logic [7:0] m_rx_data, m_tx_data;
    logic       m_rx_full, m_tx_full, m_ovr, m_udr;
    logic [1:0] m_ctrl;

    wb_spi_slave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_adr_i (wb_adr),
        .wb_dat_i (wb_dat),
        .wb_dat_o (wb_dat_o),
        .wb_we_i  (wb_we),
        .wb_stb_i (wb_stb),
        .wb_cyc_i (wb_cyc),
        .wb_ack_o (wb_ack_o),
        .sclk     (sclk),
        .mosi     (mosi),
        .cs_n     (cs_n),
        .miso     (miso)
`ifdef SPI_SLV_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        m_rx_data = 8'h00; m_tx_data = 8'h00;
        m_rx_full = 1'b0;  m_tx_full = 1'b0;
        m_ovr = 1'b0;      m_udr = 1'b0;
        m_ctrl = 2'b00;
    endtask

    // Byte the master will see for a frame start or back-to-back reload
    task automatic m_load(output logic [7:0] out);
        if (m_tx_full) begin
            out = m_tx_data;
            m_tx_full = 1'b0;
        end else begin
            out = 8'h00;
            m_udr = 1'b1;
        end
    endtask

    task automatic m_byte_done(input logic [7:0] b, input bit read_now);
        if (!m_rx_full || read_now) begin
            m_rx_data = b;
            m_rx_full = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic m_write(input logic [31:0] a, input logic [31:0] d);
        case (a[3:2])
            2'd0: begin m_tx_data = d[7:0]; m_tx_full = 1'b1; end
            2'd1: begin
                if (d[2]) m_ovr = 1'b0;
                if (d[3]) m_udr = 1'b0;
            end
`ifdef SPI_SLV_IRQ_EN
            2'd2: m_ctrl = d[1:0];
`endif
            default: ;
        endcase
    endtask

    task automatic m_read(input logic [31:0] a, output logic [31:0] exp);
        case (a[3:2])
            2'd0: begin exp = {24'b0, m_rx_data}; m_rx_full = 1'b0; end
            2'd1: exp = {27'b0, 1'b0, m_udr, m_ovr, m_tx_full, m_rx_full};
`ifdef SPI_SLV_IRQ_EN
            2'd2: exp = {30'b0, m_ctrl};
`endif
            default: exp = 32'h0;
        endcase
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        bit got = 0;
        wb_adr = a; wb_dat = d; wb_we = 1'b1; wb_stb = 1'b1; wb_cyc = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (wb_ack_o) got = 1;
        end
        wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
        m_write(a, d);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL wb_write_ack addr=%h got=no ack required=ack", a);
        end
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        bit got = 0;
        d = 32'hdead_beef;
        wb_adr = a; wb_we = 1'b0; wb_stb = 1'b1; wb_cyc = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (wb_ack_o) begin got = 1; d = wb_dat_o; end
        end
        wb_stb = 1'b0; wb_cyc = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL wb_read_ack addr=%h got=no ack required=ack", a);
        end
    endtask

    // One byte at f_clk/8; the last byte of a frame leaves sclk high
    task automatic spi_byte(input logic [7:0] mo, input bit last, output logic [7:0] mi);
        for (int i = 7; i >= 0; i--) begin
            mosi = mo[i];
            tick(4);
            mi[i] = miso;
            sclk = 1'b1;
            tick(4);
            if (!(last && i == 0)) sclk = 1'b0;
        end
    endtask

    task automatic spi_end();
        cs_n = 1'b1;
        tick(4);
        sclk = 1'b0;
        tick(6);
    endtask

    // Frame of one or two bytes; returns received miso bytes and model expectations
    task automatic spi_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                             output logic [7:0] r0, output logic [7:0] r1,
                             output logic [7:0] e0, output logic [7:0] e1);
        r1 = 8'h00; e1 = 8'h00;
        cs_n = 1'b0;
        m_load(e0);
        spi_byte(b0, n == 1, r0);
        m_byte_done(b0, 1'b0);
        if (n == 2) begin
            m_load(e1);
            spi_byte(b1, 1'b1, r1);
            m_byte_done(b1, 1'b0);
        end
        spi_end();
    endtask

    task automatic test_reset();
        logic [31:0] got, exp;
        checks++;
        if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0 || miso !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got=ack%b dat%h miso%b required=0", wb_ack_o, wb_dat_o, miso);
        end
        for (int a = 0; a < 4; a++) begin
            m_read(32'(a * 4), exp);
            wb_read(32'(a * 4), got);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reset_reg%0d got=%h required=%h", a, got, exp);
            end
        end
        wb_write(32'hC, 32'hFFFF_FFFF);
        m_read(32'hC, exp);
        wb_read(32'hC, got);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reg3_ignored got=%h required=%h", got, exp);
        end
    endtask

    task automatic test_mid_frame_reset();
        logic [7:0] r, e, r1, e1;
        logic [31:0] got, exp;
        cs_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mosi = i[0]; tick(4); sclk = 1'b1; tick(4); sclk = 1'b0;
        end
        tick(1);
        rst_n = 1'b0;
        cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        tick(2);
        rst_n = 1'b1;
        m_reset();
        tick(4);
        checks++;
        if (miso !== 1'b0) begin
            failures++;
            $display("FAIL midreset_miso got=%b required=0", miso);
        end
        m_read(32'h4, exp); wb_read(32'h4, got);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL midreset_status got=%h required=%h", got, exp);
        end
        spi_frame(1, 8'h3C, 8'h00, r, r1, e, e1);
        m_read(32'h0, exp); wb_read(32'h0, got);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL midreset_data got=%h required=%h", got, exp);
        end
        m_read(32'h4, exp); wb_read(32'h4, got);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL midreset_status2 got=%h required=%h", got, exp);
        end
        wb_write(32'h4, 32'hC);
    endtask

    task automatic test_tx_rx();
        logic [7:0] r, e, r1, e1;
        logic [31:0] got, exp;
        wb_write(32'h0, 32'hA5);
        spi_frame(1, 8'h5A, 8'h00, r, r1, e, e1);
        checks++;
        if (r !== e || r !== 8'hA5) begin
            failures++;
            $display("FAIL txrx_miso got=%h required=%h", r, e);
        end
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = (i == 1) ? 32'h0 : 32'h4;
            m_read(a, exp); wb_read(a, got);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL txrx_read%0d got=%h required=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] r0, r1, e0, e1;
        logic [31:0] got, exp;
        spi_frame(2, 8'h11, 8'h22, r0, r1, e0, e1);
        checks++;
        if (r0 !== e0 || r1 !== e1) begin
            failures++;
            $display("FAIL b2b_miso got=%h,%h required=%h,%h", r0, r1, e0, e1);
        end
        m_read(32'h4, exp); wb_read(32'h4, got);
        checks++;
        if (got !== exp || got[2] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_status got=%h required=%h", got, exp);
        end
        m_read(32'h0, exp); wb_read(32'h0, got);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL b2b_data got=%h required=%h", got, exp);
        end
        wb_write(32'h4, 32'h04);
        m_read(32'h4, exp); wb_read(32'h4, got);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL b2b_ovr_clear got=%h required=%h", got, exp);
        end
        wb_write(32'h4, 32'h08);
    endtask

    task automatic test_underrun();
        logic [7:0] r, e, r1, e1;
        logic [31:0] got, exp;
`ifdef SPI_SLV_IRQ_EN
        wb_write(32'h8, 32'h2);
`endif
        spi_frame(1, 8'hFF, 8'h00, r, r1, e, e1);
        checks++;
        if (r !== e || r !== 8'h00) begin
            failures++;
            $display("FAIL udr_miso got=%h required=%h", r, e);
        end
        m_read(32'h4, exp); wb_read(32'h4, got);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL udr_status got=%h required=%h", got, exp);
        end
`ifdef SPI_SLV_IRQ_EN
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_set got=%b required=1", irq);
        end
        wb_write(32'h4, 32'h08);
        tick(2);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_clear got=%b required=0", irq);
        end
        wb_write(32'h8, 32'h0);
`else
        wb_write(32'h4, 32'h08);
`endif
        m_read(32'h0, exp); wb_read(32'h0, got);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL udr_data got=%h required=%h", got, exp);
        end
    endtask

    task automatic test_abort();
        logic [7:0] r, e, r1, e1, dummy;
        logic [31:0] got, exp;
        cs_n = 1'b0;
        m_load(dummy);
        for (int i = 0; i < 5; i++) begin
            mosi = 1'b1; tick(4); sclk = 1'b1; tick(4); sclk = 1'b0;
        end
        tick(4);
        cs_n = 1'b1;
        tick(8);
        m_read(32'h4, exp); wb_read(32'h4, got);
        checks++;
        if (got !== exp || got[0] !== 1'b0) begin
            failures++;
            $display("FAIL abort_status got=%h required=%h", got, exp);
        end
        spi_frame(1, 8'h81, 8'h00, r, r1, e, e1);
        m_read(32'h0, exp); wb_read(32'h0, got);
        checks++;
        if (got !== exp || got !== 32'h81) begin
            failures++;
            $display("FAIL abort_data got=%h required=%h", got, exp);
        end
        wb_write(32'h4, 32'h0C);
    endtask

    task automatic test_coincident();
        logic [7:0] r, e, r1, e1, mi;
        logic [31:0] got, exp;
        bit acked;
        spi_frame(1, 8'h66, 8'h00, r, r1, e, e1);
        cs_n = 1'b0;
        m_load(e);
        for (int i = 7; i >= 1; i--) begin
            mosi = 8'h77 >> i; tick(4); mi[i] = miso; sclk = 1'b1; tick(4); sclk = 1'b0;
        end
        mosi = 1'b1;
        tick(4);
        mi[0] = miso;
        sclk = 1'b1;
        // Byte completion lands 3 edges after the pin; the read is timed to ack on that edge
        tick(2);
        wb_adr = 32'h0; wb_we = 1'b0; wb_stb = 1'b1; wb_cyc = 1'b1;
        @(posedge clk); #1;
        acked = wb_ack_o;
        got = wb_dat_o;
        wb_stb = 1'b0; wb_cyc = 1'b0;
        m_read(32'h0, exp);
        m_byte_done(8'h77, 1'b1);
        tick(3);
        spi_end();
        checks++;
        if (!acked || got !== exp || got !== 32'h66) begin
            failures++;
            $display("FAIL coinc_read got=%h ack=%b required=%h", got, acked, exp);
        end
        m_read(32'h4, exp); wb_read(32'h4, got);
        checks++;
        if (got !== exp || got[2:0] !== 3'b001) begin
            failures++;
            $display("FAIL coinc_status got=%h required=%h", got, exp);
        end
        m_read(32'h0, exp); wb_read(32'h0, got);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL coinc_next got=%h required=%h", got, exp);
        end
        wb_write(32'h4, 32'h0C);
    endtask

    task automatic test_random();
        logic [7:0] r0, r1, e0, e1, b0, b1;
        logic [31:0] got, exp, rnd;
        for (int it = 0; it < 16; it++) begin
            rnd = $urandom;
            b0 = 8'($urandom); b1 = 8'($urandom);
            if (rnd[0]) wb_write(32'h0, {24'b0, 8'($urandom)});
            spi_frame(rnd[1] ? 2 : 1, b0, b1, r0, r1, e0, e1);
            checks++;
            if (r0 !== e0 || r1 !== e1) begin
                failures++;
                $display("FAIL rand%0d_miso got=%h,%h required=%h,%h", it, r0, r1, e0, e1);
            end
            m_read(32'h4, exp); wb_read(32'h4, got);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL rand%0d_status got=%h required=%h", it, got, exp);
            end
            if (rnd[2]) begin
                m_read(32'h0, exp); wb_read(32'h0, got);
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL rand%0d_data got=%h required=%h", it, got, exp);
                end
            end
            if (rnd[3]) wb_write(32'h4, {28'b0, rnd[5:4], 2'b00});
        end
    endtask

    initial begin
        m_reset();
        tick(3);
        rst_n = 1'b1;
        tick(2);
        test_reset();
        test_mid_frame_reset();
        test_tx_rx();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_coincident();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
